// File: rtl/module_rgb_scheduler.sv
// Round-robin time-sharing of one RGB indicator between N_REQ status sources.
// Each grant holds the LED for a fixed dwell slot, followed by an idle-colour gap.
module module_rgb_scheduler #(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [3*N_REQ-1:0]   color_i,
    input  logic [2:0]           idle_color_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [2:0]           rgb_sel_o,
    output logic                 busy_o,
    output logic                 slot_done_o
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int LW         = $clog2(N_REQ);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LAST_RST   = LW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [LW-1:0]      r_last;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_rgb;
    logic               r_slot_done;

    logic [LW-1:0]      w_winner;
    logic               w_any_req;
    logic               w_owner_req;
    logic [2:0]         w_owner_color;

    // Walk from the farthest candidate back to the nearest so the nearest set bit
    // after 'last' is the one that sticks; 'last' itself has lowest priority.
    function automatic logic [LW-1:0] f_next_winner(
        input logic [N_REQ-1:0] req,
        input logic [LW-1:0]    last
    );
        logic [LW-1:0] win;
        logic [LW-1:0] sel;
        int            idx;
        win = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            sel = LW'(idx);
            if (req[sel]) win = sel;
        end
        return win;
    endfunction

    function automatic logic [N_REQ-1:0] f_onehot(input logic [LW-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        w_winner    = f_next_winner(req_i, r_last);
        w_any_req   = |req_i;
        w_owner_req = req_i[r_last];
        w_owner_color = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (LW'(k) == r_last) w_owner_color = color_i[3*k +: 3];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_last      <= LAST_RST;
            r_cnt       <= '0;
            r_rgb       <= 3'b000;
            r_slot_done <= 1'b0;
        end else begin
            r_slot_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rgb <= idle_color_i;
                    if (w_any_req) begin
                        r_gnt   <= f_onehot(w_winner);
                        r_last  <= w_winner;
                        r_cnt   <= DWELL_LOAD;
                        r_state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    r_rgb <= w_owner_color;
                    // Expiry and release share one exit, so both together give one pulse.
                    if ((r_cnt == '0) || !w_owner_req) begin
                        r_slot_done <= 1'b1;
                        r_gnt       <= '0;
                        r_cnt       <= GAP_LOAD;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    r_rgb <= idle_color_i;
                    r_gnt <= '0;
                    if (r_cnt == '0) begin
                        if (w_any_req) begin
                            r_gnt   <= f_onehot(w_winner);
                            r_last  <= w_winner;
                            r_cnt   <= DWELL_LOAD;
                            r_state <= ST_SHOW;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                    r_rgb   <= idle_color_i;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign rgb_sel_o   = r_rgb;
    assign busy_o      = (r_state != ST_IDLE);
    assign slot_done_o = r_slot_done;

endmodule

// File: tb/tb_module_rgb_scheduler.sv
// Bench for module_rgb_scheduler: directed scenarios plus random traffic,
// all checked against a slot/gap-level reference model.
module tb_module_rgb_scheduler;

    localparam int N = 4;
    localparam int D = 8;
    localparam int G = 2;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_i;
    logic [3*N-1:0]   color_i;
    logic [2:0]       idle_color_i;
    logic [N-1:0]     gnt_o;
    logic [2:0]       rgb_sel_o;
    logic             busy_o;
    logic             slot_done_o;

    module_rgb_scheduler #(
        .N_REQ       (N),
        .DWELL_CYCLES(D),
        .GAP_CYCLES  (G)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .color_i     (color_i),
        .idle_color_i(idle_color_i),
        .gnt_o       (gnt_o),
        .rgb_sel_o   (rgb_sel_o),
        .busy_o      (busy_o),
        .slot_done_o (slot_done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the LED, how long they have shown, how much gap remains.
    int           m_owner;
    int           m_elapsed;
    int           m_gap;
    int           m_last;
    logic [N-1:0] e_gnt;
    logic [2:0]   e_rgb;
    logic         e_done;
    logic         e_busy;

    task automatic model_outs();
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_busy = (m_owner >= 0) || (m_gap > 0);
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_elapsed = 0;
        m_gap     = 0;
        m_last    = N - 1;
        e_rgb     = 3'b000;
        e_done    = 1'b0;
        model_outs();
    endtask

    task automatic model_grant();
        bit found = 0;
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (!found && req_i[c]) begin
                found     = 1;
                m_owner   = c;
                m_last    = c;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic model_update();
        if (rst_i) begin
            model_reset();
            return;
        end
        e_rgb  = (m_owner >= 0) ? color_i[3*m_owner +: 3] : idle_color_i;
        e_done = 1'b0;
        if (m_owner >= 0) begin
            m_elapsed++;
            if (m_elapsed == D || !req_i[m_owner]) begin
                e_done  = 1'b1;
                m_owner = -1;
                m_gap   = G;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && req_i != '0) model_grant();
        end else if (req_i != '0) begin
            model_grant();
        end
        model_outs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = '0; color_i = '0; idle_color_i = 3'b000;
        model_reset();
        tick(); tick();
        n_vec++; if (gnt_o !== '0)      begin n_err++; $display("FAIL reset gnt: got %b want 0000", gnt_o); end
        n_vec++; if (rgb_sel_o !== '0)  begin n_err++; $display("FAIL reset rgb: got %b want 000", rgb_sel_o); end
        n_vec++; if (busy_o !== 1'b0)   begin n_err++; $display("FAIL reset busy: got %b want 0", busy_o); end
        n_vec++; if (slot_done_o !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", slot_done_o); end
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++; if (gnt_o !== e_gnt)     begin n_err++; $display("FAIL idle gnt c%0d: got %b want %b", i, gnt_o, e_gnt); end
            n_vec++; if (rgb_sel_o !== e_rgb) begin n_err++; $display("FAIL idle rgb c%0d: got %b want %b", i, rgb_sel_o, e_rgb); end
            n_vec++; if (busy_o !== e_busy)   begin n_err++; $display("FAIL idle busy c%0d: got %b want %b", i, busy_o, e_busy); end
            n_vec++; if (slot_done_o !== 1'b0) begin n_err++; $display("FAIL idle done c%0d: got %b want 0", i, slot_done_o); end
        end
    endtask

    task automatic test_single();
        color_i = {$urandom} & 12'hFF8 | 12'h005;
        req_i = 4'b0001;
        tick();
        n_vec++; if (gnt_o !== 4'b0001)   begin n_err++; $display("FAIL single first gnt: got %b want 0001", gnt_o); end
        n_vec++; if (rgb_sel_o !== 3'b000) begin n_err++; $display("FAIL single first rgb: got %b want 000", rgb_sel_o); end
        for (int j = 1; j <= 25; j++) begin
            tick();
            if (j == 1) begin
                n_vec++; if (rgb_sel_o !== 3'b101) begin n_err++; $display("FAIL single colour: got %b want 101", rgb_sel_o); end
            end
            if (j == 8) begin
                n_vec++; if (slot_done_o !== 1'b1) begin n_err++; $display("FAIL single expiry pulse: got %b want 1", slot_done_o); end
            end
            if (j == 10) begin
                n_vec++; if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL single regrant: got %b want 0001", gnt_o); end
            end
            n_vec++; if (gnt_o !== e_gnt)       begin n_err++; $display("FAIL single gnt c%0d: got %b want %b", j, gnt_o, e_gnt); end
            n_vec++; if (rgb_sel_o !== e_rgb)   begin n_err++; $display("FAIL single rgb c%0d: got %b want %b", j, rgb_sel_o, e_rgb); end
            n_vec++; if (slot_done_o !== e_done) begin n_err++; $display("FAIL single done c%0d: got %b want %b", j, slot_done_o, e_done); end
            n_vec++; if (busy_o !== e_busy)     begin n_err++; $display("FAIL single busy c%0d: got %b want %b", j, busy_o, e_busy); end
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int want[5] = '{0, 1, 3, 0, 1};
        logic [N-1:0] prev = '0;
        apply_reset();
        color_i = 12'o7531;
        req_i = 4'b1011;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (prev == '0 && gnt_o != '0) begin
                for (int k = 0; k < N; k++) if (gnt_o[k]) order.push_back(k);
            end
            prev = gnt_o;
            n_vec++; if (!$onehot0(gnt_o))     begin n_err++; $display("FAIL rr onehot c%0d: got %b", j, gnt_o); end
            n_vec++; if (gnt_o !== e_gnt)       begin n_err++; $display("FAIL rr gnt c%0d: got %b want %b", j, gnt_o, e_gnt); end
            n_vec++; if (rgb_sel_o !== e_rgb)   begin n_err++; $display("FAIL rr rgb c%0d: got %b want %b", j, rgb_sel_o, e_rgb); end
            n_vec++; if (slot_done_o !== e_done) begin n_err++; $display("FAIL rr done c%0d: got %b want %b", j, slot_done_o, e_done); end
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (k >= order.size()) begin
                n_err++; $display("FAIL rr order slot%0d: got none want %0d", k, want[k]);
            end else if (order[k] != want[k]) begin
                n_err++; $display("FAIL rr order slot%0d: got %0d want %0d", k, order[k], want[k]);
            end
        end
    endtask

    task automatic test_release();
        apply_reset();
        color_i = 12'(($urandom));
        req_i = 4'b1100;
        tick();
        n_vec++; if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL release grant: got %b want 0100", gnt_o); end
        tick(); tick();
        req_i = 4'b1000;
        tick();
        n_vec++; if (slot_done_o !== 1'b1) begin n_err++; $display("FAIL release pulse: got %b want 1", slot_done_o); end
        n_vec++; if (gnt_o !== 4'b0000)    begin n_err++; $display("FAIL release gnt drop: got %b want 0000", gnt_o); end
        tick(); tick();
        n_vec++; if (gnt_o !== 4'b1000)    begin n_err++; $display("FAIL release next grant: got %b want 1000", gnt_o); end
        for (int j = 0; j < 12; j++) begin
            tick();
            n_vec++; if (gnt_o !== e_gnt)       begin n_err++; $display("FAIL release gnt c%0d: got %b want %b", j, gnt_o, e_gnt); end
            n_vec++; if (slot_done_o !== e_done) begin n_err++; $display("FAIL release done c%0d: got %b want %b", j, slot_done_o, e_done); end
            n_vec++; if (rgb_sel_o !== e_rgb)   begin n_err++; $display("FAIL release rgb c%0d: got %b want %b", j, rgb_sel_o, e_rgb); end
        end
    endtask

    task automatic test_live_color();
        apply_reset();
        color_i = 12'o0060;
        req_i = 4'b0010;
        tick(); tick(); tick();
        n_vec++; if (rgb_sel_o !== 3'b110) begin n_err++; $display("FAIL colour before: got %b want 110", rgb_sel_o); end
        color_i = 12'o0030;
        tick();
        n_vec++; if (rgb_sel_o !== 3'b011) begin n_err++; $display("FAIL colour follow: got %b want 011", rgb_sel_o); end
        n_vec++; if (gnt_o !== 4'b0010)    begin n_err++; $display("FAIL colour gnt: got %b want 0010", gnt_o); end
        n_vec++; if (rgb_sel_o !== e_rgb)  begin n_err++; $display("FAIL colour model: got %b want %b", rgb_sel_o, e_rgb); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_i = 4'b0001;
        color_i = 12'o0007;
        for (int j = 0; j < 4; j++) tick();
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        n_vec++; if (gnt_o !== '0)        begin n_err++; $display("FAIL arst gnt: got %b want 0000", gnt_o); end
        n_vec++; if (rgb_sel_o !== '0)    begin n_err++; $display("FAIL arst rgb: got %b want 000", rgb_sel_o); end
        n_vec++; if (busy_o !== 1'b0)     begin n_err++; $display("FAIL arst busy: got %b want 0", busy_o); end
        n_vec++; if (slot_done_o !== 1'b0) begin n_err++; $display("FAIL arst done: got %b want 0", slot_done_o); end
        req_i = 4'b1000;
        tick();
        rst_i = 1'b0;
        tick();
        n_vec++; if (gnt_o !== 4'b1000) begin n_err++; $display("FAIL arst first grant: got %b want 1000", gnt_o); end
        n_vec++; if (gnt_o !== e_gnt)   begin n_err++; $display("FAIL arst model gnt: got %b want %b", gnt_o, e_gnt); end
    endtask

    task automatic test_random();
        apply_reset();
        idle_color_i = 3'($urandom);
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 7) == 0) req_i = 4'($urandom);
            if ($urandom_range(0, 5) == 0) color_i = 12'($urandom);
            if ($urandom_range(0, 99) == 0) idle_color_i = 3'($urandom);
            tick();
            n_vec++; if (!$onehot0(gnt_o))     begin n_err++; $display("FAIL rand onehot c%0d: got %b", j, gnt_o); end
            n_vec++; if (gnt_o !== e_gnt)       begin n_err++; $display("FAIL rand gnt c%0d: got %b want %b", j, gnt_o, e_gnt); end
            n_vec++; if (rgb_sel_o !== e_rgb)   begin n_err++; $display("FAIL rand rgb c%0d: got %b want %b", j, rgb_sel_o, e_rgb); end
            n_vec++; if (slot_done_o !== e_done) begin n_err++; $display("FAIL rand done c%0d: got %b want %b", j, slot_done_o, e_done); end
            n_vec++; if (busy_o !== e_busy)     begin n_err++; $display("FAIL rand busy c%0d: got %b want %b", j, busy_o, e_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_release();
        test_live_color();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/module_rgb_scheduler.md
Name: module_rgb_scheduler

Overview:
- Time-shares one RGB LED indicator between N_REQ status sources, for example SPI activity, error and heartbeat.
- Each requester presents a 3-bit colour and a level request.
- The scheduler grants one requester at a time, round-robin, for a fixed dwell slot, with a short idle-colour gap between slots.
- rgb_sel_o drives the colour input of the existing RGB PWM LED driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 50_000_000, length of one grant slot in clk_i cycles (≥2).
- GAP_CYCLES, 5_000_000, length of the idle-colour gap between consecutive slots in clk_i cycles (≥1).
- Counter width is $clog2(max(DWELL_CYCLES, GAP_CYCLES)+1).

Ports:
- clk_i, in, 1: system clock; all logic on the rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- req_i, in, N_REQ: level request; bit k is requester k.
- color_i, in, 3*N_REQ: packed colours; requester k uses bits [3k+2:3k].
- idle_color_i, in, 3: colour shown when nothing is granted and during gaps.
- gnt_o, out, N_REQ: one-hot grant, all-zero when no grant.
- rgb_sel_o, out, 3: registered colour to the LED driver.
- busy_o, out, 1: high in SHOW or GAP.
- slot_done_o, out, 1: one-cycle pulse when a slot ends, by expiry or by release.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, gnt_o=0, busy_o=0, slot_done_o=0, counter=0.
  - rgb_sel_o=3'b000.
  - Round-robin pointer last=N_REQ-1, so requester 0 wins first.
- The FSM has three states: IDLE, SHOW and GAP.
- IDLE:
  - rgb_sel_o <= idle_color_i every cycle.
  - If req_i≠0 at an edge, that same edge grants the winner: gnt_o one-hot, last<=winner, counter<=DWELL_CYCLES-1, state<=SHOW.
  - Latency is 1 cycle from req_i asserted to gnt_o visible.
- Winner selection: the first set bit of req_i searching from (last+1) mod N_REQ upward, with wrap-around.
- SHOW:
  - rgb_sel_o <= color_i[winner] each cycle. It tracks live colour changes with 1-cycle latency.
  - The counter decrements each cycle.
  - Expiry (counter==0): slot_done_o=1 for one cycle, gnt_o<=0, counter<=GAP_CYCLES-1, state<=GAP.
  - Release (granted req bit low while counter≠0): the same transition as expiry, on the next edge. slot_done_o pulses and the remaining dwell is discarded.
  - Release and expiry in the same cycle produce a single slot_done_o pulse.
- GAP:
  - rgb_sel_o <= idle_color_i and gnt_o=0. The counter decrements.
  - At counter==0:
    - If req_i≠0, grant the next winner exactly as from IDLE (state<=SHOW).
    - Otherwise go to IDLE.
  - Requests rising or falling during GAP are only evaluated at the gap's last edge.
- Fairness:
  - A requester holding req_i continuously cannot be granted twice in a row while another request is pending at the arbitration edge.
  - A single persistent requester is re-granted after every gap.
- Outputs:
  - gnt_o is never multi-hot.
  - busy_o = (state≠IDLE).
- Reset mid-SHOW or mid-GAP aborts immediately. No slot_done_o pulse is generated.
- Out-of-range winner indices cannot occur. If N_REQ is not a power of two, the pointer wraps explicitly at N_REQ-1.

Test Plan:
All scenarios use DWELL_CYCLES=8, GAP_CYCLES=2, N_REQ=4, idle_color_i=3'b000.
1. Reset release, req_i=0 for 20 cycles -> gnt_o=0, busy_o=0, rgb_sel_o=000 throughout, with no slot_done_o.
2. req_i=4'b0001 held, color_i[2:0]=101:
   - gnt_o=0001 one cycle after req, rgb_sel_o=101 one cycle later.
   - slot_done_o pulses after 8 SHOW cycles, then 2 gap cycles with rgb_sel_o=000, then re-grant to requester 0.
3. req_i=4'b1011 held -> grant order 0,1,3,0,1,... Each slot is 8 cycles with a 2-cycle gap between slots, and gnt_o is never multi-hot.
4. Requester 2 granted, req_i[2] dropped 3 cycles into the slot -> slot_done_o pulses on the next edge, GAP follows, then requester 3 (if pending) is granted.
5. Change color_i[5:3] from 110 to 011 mid-slot while requester 1 is granted -> rgb_sel_o follows one cycle later and gnt_o is unchanged.
6. Assert rst_i asynchronously mid-SHOW -> gnt_o=0, rgb_sel_o=000, busy_o=0 immediately, no slot_done_o. After release with req_i=4'b1000, the first grant goes to requester 3 (pointer reset to N_REQ-1).
